// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot and run controller for the single-clock MIPS fetch path.
//
// Streams a program image into instruction memory over a valid/ready
// interface (sequential word addresses from 0) while holding the core in
// reset, then releases the core and gates PC advance for halt/step debug.
//
// Optional feature: define IMEM_STEP_EN to enable single-step while halted.
//
// Ports:
//   CLK           clock, all state on rising edge
//   RST           synchronous active-low reset
//   ld_start      pulse, begin a load session
//   ld_valid      host word valid
//   ld_data       host instruction word
//   ld_last       final word of the image (qualifies ld_valid)
//   ld_ready      controller accepts a word this cycle
//   imem_we       instruction-memory write enable
//   imem_waddr    instruction-memory word address
//   imem_wdata    instruction-memory write data
//   cpu_rst       active-high core reset
//   pc_en         PC advance enable
//   dbg_halt      level, stop PC advance while high
//   dbg_step      pulse, advance one instruction while halted
//   busy          high in LOAD and DRAIN
//   load_err      sticky image-overflow flag
//   words_loaded  words accepted in the last/current session
module imem_boot_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              pc_en,
  input  logic              dbg_halt,
  input  logic              dbg_step,
  output logic              busy,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_STEP_EN
  localparam bit StepEn = 1'b1;
`else
  localparam bit StepEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StRun, StHalt} state_e;

  state_e          state;
  logic            step_q;
  logic            accept;
  logic            step_rise;
  logic [ADDR_W:0] count_inc;

  // words_loaded doubles as the session word counter.
  assign accept    = ld_valid & ld_ready;
  assign count_inc = words_loaded + {{ADDR_W{1'b0}}, 1'b1};
  // Step is edge-detected so a held dbg_step yields a single instruction.
  assign step_rise = StepEn & dbg_step & ~step_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= StIdle;
      step_q       <= 1'b0;
      ld_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      pc_en        <= 1'b0;
      busy         <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      step_q  <= dbg_step;
      imem_we <= 1'b0;
      case (state)
        StIdle: begin
          cpu_rst <= 1'b1;
          pc_en   <= 1'b0;
          if (ld_start) begin
            state        <= StLoad;
            words_loaded <= '0;
            load_err     <= 1'b0;
            ld_ready     <= 1'b1;
            busy         <= 1'b1;
          end
        end

        StLoad: begin
          if (accept) begin
            imem_we      <= 1'b1;
            imem_waddr   <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= ld_data;
            words_loaded <= count_inc;
            if (ld_last) begin
              state    <= StDrain;
              ld_ready <= 1'b0;
            end else if (count_inc[ADDR_W]) begin
              // Memory full without a last word: abort, core stays in reset.
              state    <= StIdle;
              ld_ready <= 1'b0;
              load_err <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        StDrain: begin
          state   <= StRun;
          cpu_rst <= 1'b0;
          pc_en   <= 1'b1;
          busy    <= 1'b0;
        end

        StRun, StHalt: begin
          if (ld_start) begin
            state        <= StLoad;
            cpu_rst      <= 1'b1;
            pc_en        <= 1'b0;
            words_loaded <= '0;
            load_err     <= 1'b0;
            ld_ready     <= 1'b1;
            busy         <= 1'b1;
          end else if (state == StRun) begin
            if (dbg_halt) begin
              state <= StHalt;
              pc_en <= 1'b0;
            end else begin
              pc_en <= 1'b1;
            end
          end else if (!dbg_halt) begin
            // Resume takes priority over a coincident step.
            state <= StRun;
            pc_en <= 1'b1;
          end else begin
            pc_en <= step_rise;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed self-checking bench for imem_boot_ctrl (ADDR_W = 2, depth 4).
// Expected memory writes go into a scoreboard queue as words are offered;
// a negedge monitor pops and compares every write the DUT issues.
module tb_imem_boot_ctrl;

  localparam int unsigned AW = 2;

`ifdef IMEM_STEP_EN
  localparam logic STEP_EXP = 1'b1;
`else
  localparam logic STEP_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start, ld_valid, ld_last, dbg_halt, dbg_step;
  logic [31:0]   ld_data;
  logic          ld_ready, imem_we, cpu_rst, pc_en, busy, load_err;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];

  always #5 clk = ~clk;

  imem_boot_ctrl #(.ADDR_W(AW)) dut (
    .CLK          (clk),
    .RST          (rst),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .pc_en        (pc_en),
    .dbg_halt     (dbg_halt),
    .dbg_step     (dbg_step),
    .busy         (busy),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [AW+31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr %0h data %h required none", imem_waddr,
                 imem_wdata);
      end else begin
        e = exp_q.pop_front();
        assert ({imem_waddr, imem_wdata} === e) else begin
          errors++;
          $error("FAIL write got %h required %h", {imem_waddr, imem_wdata}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_waddr"}, {30'd0, imem_waddr}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_pc_en"}, {31'd0, pc_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_words"}, {29'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = 32'h0; dbg_halt = 1'b0; dbg_step = 1'b0;
    #1;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Four-word image filling memory exactly, back to back.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("start_ready", {31'd0, ld_ready}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h2008_0001 + i;
      ld_last  = (i == 3);
      exp_q.push_back({i[AW-1:0], ld_data});
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
    chk("drain_we", {31'd0, imem_we}, 32'd1);
    chk("drain_ready", {31'd0, ld_ready}, 32'd0);
    chk("drain_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("drain_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    chk("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("run_pc_en", {31'd0, pc_en}, 32'd1);
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_words", {29'd0, words_loaded}, 32'd4);

    // Halt for three cycles: pc_en low for exactly three cycles.
    dbg_halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_pc_en", {31'd0, pc_en}, 32'd0);
      chk("halt_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    end
    dbg_halt = 1'b0;
    tick();
    chk("resume_pc_en", {31'd0, pc_en}, 32'd1);

    // Step held for four cycles while halted.
    dbg_halt = 1'b1;
    tick();
    chk("step_halted", {31'd0, pc_en}, 32'd0);
    dbg_step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("step_pc_en", {31'd0, pc_en}, (i == 0) ? {31'd0, STEP_EXP} : 32'd0);
    end
    dbg_step = 1'b0;
    tick();
    chk("step_after", {31'd0, pc_en}, 32'd0);
    dbg_halt = 1'b0;
    tick();
    chk("step_resume", {31'd0, pc_en}, 32'd1);

    // Reload from RUN with ld_valid every other cycle.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reload_pc_en", {31'd0, pc_en}, 32'd0);
    chk("reload_words", {29'd0, words_loaded}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA500_0000 + i;
      ld_last  = (i == 2);
      exp_q.push_back({i[AW-1:0], ld_data});
      tick();
      ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
      if (i < 2) begin
        tick();
        chk("gap_we", {31'd0, imem_we}, 32'd0);
      end
    end
    tick();
    chk("reload_run_pc_en", {31'd0, pc_en}, 32'd1);
    chk("reload_run_words", {29'd0, words_loaded}, 32'd3);

    // Overflow: five words without ld_last into a four-word memory.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h1111_0000 + i;
      if (i < 4) exp_q.push_back({i[AW-1:0], ld_data});
      tick();
      chk("ovf_ready", {31'd0, ld_ready}, (i < 3) ? 32'd1 : 32'd0);
    end
    ld_valid = 1'b0;
    chk("ovf_err", {31'd0, load_err}, 32'd1);
    chk("ovf_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("ovf_busy", {31'd0, busy}, 32'd0);
    chk("ovf_pc_en", {31'd0, pc_en}, 32'd0);
    chk("ovf_words", {29'd0, words_loaded}, 32'd4);

    // ld_start with ld_valid in IDLE: the word is not taken.
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hBAD0_0000;
    tick();
    ld_start = 1'b0;
    chk("start_valid_words", {29'd0, words_loaded}, 32'd0);
    chk("start_valid_err", {31'd0, load_err}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      ld_data = 32'h3300_0000 + i;
      exp_q.push_back({i[AW-1:0], ld_data});
      tick();
    end
    ld_valid = 1'b0;

    // Reset mid-load, then a fresh load restarts at address 0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_reset_vals("midload_rst");
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h4400_0007;
    exp_q.push_back({{AW{1'b0}}, ld_data});
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    chk("restart_pc_en", {31'd0, pc_en}, 32'd1);
    chk("restart_words", {29'd0, words_loaded}, 32'd1);
    tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
